// File: rtl/onn_phase_bank_if.sv
// Phase-bank port bundle: triggers and candidate phases in, phases and flags out.
// ONN_PIN_EN adds a per-neuron pin vector.
interface onn_phase_bank_if #(
  parameter int N             = 8,
  parameter int PHASE_W       = 4,
  parameter int STABLE_CHECKS = 3
);
  localparam int CNT_W = $clog2(STABLE_CHECKS + 1);

  logic                 drop;
  logic                 state_check;
  logic [N*PHASE_W-1:0] ini_phase;
  logic [N*PHASE_W-1:0] phase;
  logic [N*PHASE_W-1:0] phi_out;
  logic [N-1:0]         state_changed;
  logic                 any_changed;
  logic                 check_done;
  logic [CNT_W-1:0]     stable_cnt;
  logic                 converged;
`ifdef ONN_PIN_EN
  logic [N-1:0]         pin;
`endif

  modport master (
    output drop,
    output state_check,
    output ini_phase,
    output phase,
`ifdef ONN_PIN_EN
    output pin,
`endif
    input  phi_out,
    input  state_changed,
    input  any_changed,
    input  check_done,
    input  stable_cnt,
    input  converged
  );

  modport slave (
    input  drop,
    input  state_check,
    input  ini_phase,
    input  phase,
`ifdef ONN_PIN_EN
    input  pin,
`endif
    output phi_out,
    output state_changed,
    output any_changed,
    output check_done,
    output stable_cnt,
    output converged
  );
endinterface

// File: rtl/onn_phase_bank.sv
// Bank of N oscillator phase registers with change flags and convergence tracking.
// Optional ONN_PIN_EN: pinned neurons hold their phase on check events.
module onn_phase_bank #(
  parameter int N             = 8,
  parameter int PHASE_W       = 4,
  parameter int STABLE_CHECKS = 3
) (
  input logic               clk,
  input logic               re,
  onn_phase_bank_if.slave   bus
);
  localparam int W     = N * PHASE_W;
  localparam int CNT_W = $clog2(STABLE_CHECKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CHECKS);

  logic             drop_d;
  logic             check_d;
  logic             drop_ev;
  logic             check_ev;
  logic             check_only;

  logic [W-1:0]     phi_q;
  logic [W-1:0]     phi_nx;
  logic [W-1:0]     chk_phi;
  logic [N-1:0]     chg_q;
  logic [N-1:0]     chg_nx;
  logic [N-1:0]     chk_vec;
  logic [N-1:0]     hold;
  logic             any_q;
  logic             any_nx;
  logic             done_q;
  logic             done_nx;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nx;
  logic [CNT_W-1:0] cnt_chk;
  logic             conv_q;
  logic             conv_nx;

`ifdef ONN_PIN_EN
  assign hold = bus.pin;
`else
  assign hold = '0;
`endif

  assign drop_ev    = bus.drop & ~drop_d;
  assign check_ev   = bus.state_check & ~check_d;
  // drop takes precedence; a coincident check is simply discarded
  assign check_only = check_ev & ~drop_ev;

  always_comb begin
    chk_phi = phi_q;
    chk_vec = '0;
    for (int i = 0; i < N; i++) begin
      if (!hold[i] &&
          phi_q[i*PHASE_W +: PHASE_W] !=
          bus.phase[i*PHASE_W +: PHASE_W]) begin
        chk_vec[i] = 1'b1;
        chk_phi[i*PHASE_W +: PHASE_W] =
          bus.phase[i*PHASE_W +: PHASE_W];
      end
    end
  end

  always_comb begin
    if (|chk_vec)
      cnt_chk = '0;
    else if (cnt_q == CNT_MAX)
      cnt_chk = cnt_q;
    else
      cnt_chk = cnt_q + CNT_W'(1);
  end

  always_comb begin
    phi_nx  = phi_q;
    chg_nx  = chg_q;
    any_nx  = any_q;
    done_nx = 1'b0;
    cnt_nx  = cnt_q;
    conv_nx = conv_q;
    unique case (1'b1)
      drop_ev: begin
        phi_nx  = bus.ini_phase;
        chg_nx  = '1;
        any_nx  = 1'b1;
        cnt_nx  = '0;
        conv_nx = 1'b0;
      end
      check_only: begin
        phi_nx  = chk_phi;
        chg_nx  = chk_vec;
        any_nx  = |chk_vec;
        done_nx = 1'b1;
        cnt_nx  = cnt_chk;
        conv_nx = (cnt_chk == CNT_MAX);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge re) begin
    if (re) begin
      drop_d  <= 1'b0;
      check_d <= 1'b0;
      phi_q   <= '1;
      chg_q   <= '0;
      any_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      conv_q  <= 1'b0;
    end else begin
      drop_d  <= bus.drop;
      check_d <= bus.state_check;
      phi_q   <= phi_nx;
      chg_q   <= chg_nx;
      any_q   <= any_nx;
      done_q  <= done_nx;
      cnt_q   <= cnt_nx;
      conv_q  <= conv_nx;
    end
  end

  assign bus.phi_out       = phi_q;
  assign bus.state_changed = chg_q;
  assign bus.any_changed   = any_q;
  assign bus.check_done    = done_q;
  assign bus.stable_cnt    = cnt_q;
  assign bus.converged     = conv_q;
endmodule
